// File: rtl/sun2_prom_pkg.sv
// Shared definitions for the Sun-2 boot PROM sequencer: state encoding,
// idle strobe value, wait-count bounds and the byte-lane helper.
package sun2_prom_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_LATCH   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;
    localparam logic [2:0] ST_RECOVER = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        SETUP   = ST_SETUP,
        ACCESS  = ST_ACCESS,
        LATCH   = ST_LATCH,
        ACK     = ST_ACK,
        ERR     = ST_ERR,
        RECOVER = ST_RECOVER
    } prom_state_e;

    // {ce_h_n, ce_l_n, oe_n} with both chips deselected
    localparam logic [2:0] STROBE_IDLE = 3'b111;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Unstrobed byte lanes read back as zero
    function automatic logic [15:0] lane_data(input logic [15:0] d,
                                              input logic       uds_n,
                                              input logic       lds_n);
        return {(uds_n ? 8'h00 : d[15:8]), (lds_n ? 8'h00 : d[7:0])};
    endfunction

endpackage

// File: rtl/prom_wait_counter.sv
// 4-bit loadable down-counter with zero flag; times the PROM OE_n access window.
module prom_wait_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_r;

    // Count register: load has priority, decrement saturates at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/sun2_bootprom_ctl.sv
// Bus-cycle sequencer for the Sun-2 27256 boot PROM pair (32K x 16).
// Build option: BOOT_OVERLAY_EN maps the PROM at low memory for the reset vector fetch.
module sun2_bootprom_ctl
    import sun2_prom_pkg::*;
#(
    parameter int WAIT_CYCLES  = 3,
    parameter int BOOT_FETCHES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [14:0] word_addr,
    input  logic        low_req,
    output logic [14:0] prom_a,
    output logic        prom_ce_h_n,
    output logic        prom_ce_l_n,
    output logic        prom_oe_n,
    input  logic [15:0] prom_d,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        berr,
    output logic        boot_active
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    prom_state_e state_r, state_nxt;
    logic        start_s, active_s, hold_s, cnt_zero_s;
    logic        lane_h_s, lane_l_s;
    logic [2:0]  strobe_nxt, strobe_r;
    logic [14:0] prom_a_r;
    logic [15:0] rdata_r;
    logic        ack_r, berr_r, uds_lat_r, lds_lat_r;

    prom_wait_counter u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state_r == SETUP),
        .dec      (state_r == ACCESS),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero_s)
    );

`ifdef BOOT_OVERLAY_EN
    logic       boot_active_r, low_cyc_r;
    logic [7:0] boot_cnt_r;

    assign active_s    = req | (boot_active_r & low_req);
    // An overlay cycle is held by low_req just as a normal one is held by req
    assign hold_s      = req | (low_cyc_r & low_req);
    assign boot_active = boot_active_r;

    // Overlay arm flag and remaining vector-fetch count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boot_active_r <= 1'b1;
            boot_cnt_r    <= 8'(BOOT_FETCHES);
            low_cyc_r     <= 1'b0;
        end else begin
            if ((state_r == IDLE) && (state_nxt != IDLE)) begin
                low_cyc_r <= boot_active_r & low_req;
            end
            if ((state_r == ACK) && (state_nxt != ACK) && low_cyc_r && boot_active_r) begin
                boot_cnt_r <= boot_cnt_r - 8'd1;
                if (boot_cnt_r == 8'd1) begin
                    boot_active_r <= 1'b0;
                end
            end
        end
    end
`else
    assign active_s    = req;
    assign hold_s      = req;
    // low_req and BOOT_FETCHES have no function without the overlay
    assign boot_active = 1'b0 & low_req & (BOOT_FETCHES != 0);
`endif

    // Next-state decode
    always_comb begin
        state_nxt = state_r;
        start_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (active_s && wr) begin
                    state_nxt = ERR;
                end else if (active_s) begin
                    state_nxt = SETUP;
                    start_s   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP:   state_nxt = hold_s ? ACCESS : RECOVER;
            ACCESS: begin
                if (!hold_s) begin
                    state_nxt = RECOVER;
                end else if (cnt_zero_s) begin
                    state_nxt = LATCH;
                end else begin
                    state_nxt = ACCESS;
                end
            end
            LATCH:   state_nxt = hold_s ? ACK : RECOVER;
            ACK:     state_nxt = hold_s ? ACK : RECOVER;
            ERR:     state_nxt = hold_s ? ERR : RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes for the state being entered; lane enables come straight from the bus on cycle start
    always_comb begin
        strobe_nxt = STROBE_IDLE;
        lane_h_s   = start_s ? uds_n : uds_lat_r;
        lane_l_s   = start_s ? lds_n : lds_lat_r;
        case (state_nxt)
            SETUP:              strobe_nxt = {lane_h_s, lane_l_s, 1'b1};
            ACCESS, LATCH, ACK: strobe_nxt = {lane_h_s, lane_l_s, 1'b0};
            default:            strobe_nxt = STROBE_IDLE;
        endcase
    end

    // State, address, data and handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            prom_a_r  <= 15'h0000;
            strobe_r  <= STROBE_IDLE;
            rdata_r   <= 16'h0000;
            ack_r     <= 1'b0;
            berr_r    <= 1'b0;
            uds_lat_r <= 1'b1;
            lds_lat_r <= 1'b1;
        end else begin
            state_r  <= state_nxt;
            strobe_r <= strobe_nxt;
            ack_r    <= (state_nxt == ACK);
            berr_r   <= (state_r == ERR) && (state_nxt == ERR);
            if (start_s) begin
                prom_a_r  <= word_addr;
                uds_lat_r <= uds_n;
                lds_lat_r <= lds_n;
            end
            if ((state_r == LATCH) && (state_nxt == ACK)) begin
                rdata_r <= lane_data(prom_d, uds_lat_r, lds_lat_r);
            end
        end
    end

    assign prom_a      = prom_a_r;
    assign prom_ce_h_n = strobe_r[2];
    assign prom_ce_l_n = strobe_r[1];
    assign prom_oe_n   = strobe_r[0];
    assign rdata       = rdata_r;
    assign ack         = ack_r;
    assign berr        = berr_r;

endmodule
